// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter and its requesters / downstream consumer.
//   req   : per-requester request, bit i = requester i
//   ack   : downstream accepted the current beat this cycle
//   gnt   : registered one-hot grant, all-zero when idle
//   sel   : registered index of the granted requester, drives the 8:1 mux select
//   valid : granted and the owner is still requesting
//   busy  : a grant is currently held
// master: requester/consumer side. slave: arbiter side.
interface mux_rr_arbiter_if;
    logic [7:0] req;
    logic       ack;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       busy;

    modport master (
        output req,
        output ack,
        input  gnt,
        input  sel,
        input  valid,
        input  busy
    );

    modport slave (
        input  req,
        input  ack,
        output gnt,
        output sel,
        output valid,
        output busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 datapath select among eight requesters.
// Holds a grant until the owner withdraws or has MAX_BEATS beats accepted, then hands off on
// the same edge to the next requester after the owner.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : arbiter side of mux_rr_arbiter_if (req/ack in, gnt/sel/valid/busy out)
module mux_rr_arbiter #(
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned CW        = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux_rr_arbiter_if.slave     bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      gnt_q, gnt_d;
    logic [2:0]      sel_q, sel_d;

    logic            found;
    logic [2:0]      win;
    logic [2:0]      idx;
    logic            valid;
    logic            beat;
    logic            last_beat;
    logic            release_now;

    assign valid       = (state_q == StGrant) && bus.req[sel_q];
    assign beat        = valid && bus.ack;
    assign last_beat   = (cnt_q == CW'(MAX_BEATS - 1));
    // A withdrawing owner already has req[sel]=0, so searching the raw req vector is the
    // masked search; on quota the owner sits last in order because ptr = owner+1.
    assign release_now = !bus.req[sel_q] || (beat && last_beat);

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = '0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    gnt_d   = 8'b1 << win;
                    sel_d   = win;
                    cnt_d   = '0;
                    ptr_d   = win + 3'd1;
                end
            end
            StGrant: begin
                if (release_now) begin
                    if (found) begin
                        gnt_d = 8'b1 << win;
                        sel_d = win;
                        cnt_d = '0;
                        ptr_d = win + 3'd1;
                    end else begin
                        // sel keeps its last value while idle
                        state_d = StIdle;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid;
    assign bus.busy  = (state_q == StGrant);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mux_rr_arbiter_if if4 ();
    mux_rr_arbiter_if if1 ();

    mux_rr_arbiter #(.MAX_BEATS(4), .CW(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    mux_rr_arbiter #(.MAX_BEATS(1), .CW(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic       ack;
        logic       chk_pre;
        logic       pre_valid;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       valid;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered outputs + valid of the MAX_BEATS=4 instance, sampled after an edge.
    task automatic chk4(input string tag, input logic [7:0] g, input logic [2:0] s,
                        input logic b, input logic v);
        chk({tag, ".gnt"},   32'(if4.gnt),   32'(g));
        chk({tag, ".sel"},   32'(if4.sel),   32'(s));
        chk({tag, ".busy"},  32'(if4.busy),  32'(b));
        chk({tag, ".valid"}, 32'(if4.valid), 32'(v));
    endtask

    task automatic step4(input logic r, input logic [7:0] q, input logic a);
        rst     = r;
        if4.req = q;
        if4.ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        if4.req = '0;
        if4.ack = 1'b0;
        if1.req = '0;
        if1.ack = 1'b0;

        //          rst   req    ack  chkp prev gnt    sel   busy valid
        vecs[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        // single owner 2, quota of 4 then re-grant with no gap
        vecs[4]  = '{1'b0, 8'h04, 1'b1, 1'b1, 1'b0, 8'h04, 3'd2, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h04, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 8'h04, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 8'h04, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'h04, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1};
        // owner 2 withdraws, 5 takes over; then 5 withdraws to 0 with no idle cycle
        vecs[10] = '{1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'h21, 1'b0, 1'b1, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1};
        // last owner withdraws, nobody else: idle, sel holds 0
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            rst     = vecs[i].rst;
            if4.req = vecs[i].req;
            if4.ack = vecs[i].ack;
            #1;
            if (vecs[i].chk_pre) chk($sformatf("v%0d.pre_valid", i), 32'(if4.valid),
                                     32'(vecs[i].pre_valid));
            @(posedge clk);
            #1;
            chk4($sformatf("v%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].valid);
        end

        // Ack while idle is ignored.
        step4(1'b0, 8'h00, 1'b1);
        chk4("idle_ack0", 8'h00, 3'd0, 1'b0, 1'b0);
        step4(1'b0, 8'h00, 1'b1);
        chk4("idle_ack1", 8'h00, 3'd0, 1'b0, 1'b0);

        // Ack gating: owner 3 (ptr is 1), requester 4 waiting.
        step4(1'b0, 8'h18, 1'b0);
        chk4("gate_grant", 8'h08, 3'd3, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step4(1'b0, 8'h18, 1'b0);
            chk4($sformatf("gate_hold%0d", i), 8'h08, 3'd3, 1'b1, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 8'h18, 1'b1);
            chk4($sformatf("gate_ack%0d", i), 8'h08, 3'd3, 1'b1, 1'b1);
        end
        step4(1'b0, 8'h18, 1'b1);
        chk4("gate_quota", 8'h10, 3'd4, 1'b1, 1'b1);

        // Owner 7, then reset mid-grant with an ack in flight.
        step4(1'b0, 8'h80, 1'b0);
        chk4("own7", 8'h80, 3'd7, 1'b1, 1'b1);
        step4(1'b1, 8'h80, 1'b1);
        chk4("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
        step4(1'b0, 8'h81, 1'b0);
        chk4("post_rst", 8'h01, 3'd0, 1'b1, 1'b1);
        step4(1'b0, 8'h81, 1'b0);
        chk4("post_rst_hold", 8'h01, 3'd0, 1'b1, 1'b1);
        if4.req = '0;

        // MAX_BEATS=1 rotation: one beat per grant, order 0..7 then wrap to 0.
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rot_rst.gnt", 32'(if1.gnt), 32'h0);
        rst     = 1'b0;
        if1.req = 8'hFF;
        if1.ack = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] eg;
            eg = 8'b1 << (k % 8);
            @(posedge clk);
            #1;
            chk($sformatf("rot%0d.gnt", k), 32'(if1.gnt), 32'(eg));
            chk($sformatf("rot%0d.sel", k), 32'(if1.sel), 32'(k % 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
